// File: rtl/cla64_issue_stage_if.sv
// Handshake and adder bundle for the 64-bit CLA issue stage.
// slave is the stage's view; master is the requester/adder/consumer view.
interface cla64_issue_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_c;
    logic [WIDTH-1:0] add_s;
    logic             add_p;
    logic             add_g;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;

    modport slave (
        input  in_valid, in_a, in_b, in_op,
        input  add_s, add_p, add_g,
        input  out_ready,
        output in_ready,
        output add_a, add_b, add_c,
        output out_valid, out_s, out_cout,
        output out_ovf, out_zero, out_neg
    );

    modport master (
        output in_valid, in_a, in_b, in_op,
        output add_s, add_p, add_g,
        output out_ready,
        input  in_ready,
        input  add_a, add_b, add_c,
        input  out_valid, out_s, out_cout,
        input  out_ovf, out_zero, out_neg
    );
endinterface

// File: rtl/cla64_issue_stage.sv
// Operand-issue / result-capture stage around a 64-bit CLA adder.
// Optional macro CLA_SAT_EN saturates out_s on signed overflow.
module cla64_issue_stage #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla64_issue_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic             in_ready_w;
    logic             accept;
    logic             capture;
    logic             drain;

    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_c_q, add_c_d;
    logic             cflag_q, cflag_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_s_q, out_s_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_zero_q, out_zero_d;
    logic             out_neg_q, out_neg_d;

    logic             cout_w;
    logic             ovf_w;
    logic [WIDTH-1:0] res_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE: begin
                if (accept)             state_d = EXEC;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready must not look at in_valid, so it can't form a loop upstream
    always_comb begin
        in_ready_w = (state_q == IDLE) ||
                     ((state_q == DONE) && bus.out_ready);
        accept     = bus.in_valid && in_ready_w;
        capture    = (state_q == EXEC);
        drain      = (state_q == DONE) && bus.out_ready;
    end

    always_comb begin
        cout_w = bus.add_g | (bus.add_p & add_c_q);
        ovf_w  = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                 (bus.add_s[WIDTH-1] != add_a_q[WIDTH-1]);
        res_w  = bus.add_s;
`ifdef CLA_SAT_EN
        if (ovf_w) begin
            res_w = add_a_q[WIDTH-1]
                  ? {1'b1, {(WIDTH-1){1'b0}}}
                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_c_d     = add_c_q;
        cflag_d     = cflag_q;
        out_valid_d = out_valid_q;
        out_s_d     = out_s_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_zero_d  = out_zero_q;
        out_neg_d   = out_neg_q;

        // op[0] selects subtract, op[1] selects chaining through cflag
        if (accept) begin
            add_a_d = bus.in_a;
            add_b_d = bus.in_op[0] ? ~bus.in_b : bus.in_b;
            unique case (1'b1)
                bus.in_op[1]: add_c_d = cflag_q;
                default:      add_c_d = bus.in_op[0];
            endcase
        end

        if (capture) begin
            out_s_d     = res_w;
            out_cout_d  = cout_w;
            out_ovf_d   = ovf_w;
            out_zero_d  = (res_w == '0);
            out_neg_d   = res_w[WIDTH-1];
            cflag_d     = cout_w;
            out_valid_d = 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_c_q     <= 1'b0;
            cflag_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_s_q     <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_neg_q   <= 1'b0;
        end else begin
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_c_q     <= add_c_d;
            cflag_q     <= cflag_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_zero_q  <= out_zero_d;
            out_neg_q   <= out_neg_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_c     = add_c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_neg   = out_neg_q;
endmodule

// File: tb/tb_cla64_issue_stage.sv
// Scoreboard bench for cla64_issue_stage with a behavioural CLA adder.
// Directed vectors; monitor pops expected results on each output handshake.
module tb_cla64_issue_stage;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SMAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SMIN  = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];
    res_t mon_e;
    logic [64:0] g_sum;

    cla64_issue_stage_if bus ();

    cla64_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural adder: G is the carry of A+B, P is the all-propagate term
    always_comb g_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign bus.add_s = bus.add_a + bus.add_b + {63'd0, bus.add_c};
    assign bus.add_p = &(bus.add_a ^ bus.add_b);
    assign bus.add_g = g_sum[64];

    function automatic res_t mk(logic [63:0] s, logic c, logic o,
                                logic z, logic n);
        res_t r;
        r.s = s; r.cout = c; r.ovf = o; r.zero = z; r.neg = n;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none",
                         bus.out_s);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_s",    bus.out_s,    mon_e.s);
                chk("out_cout", {63'd0, bus.out_cout}, {63'd0, mon_e.cout});
                chk("out_ovf",  {63'd0, bus.out_ovf},  {63'd0, mon_e.ovf});
                chk("out_zero", {63'd0, bus.out_zero}, {63'd0, mon_e.zero});
                chk("out_neg",  {63'd0, bus.out_neg},  {63'd0, mon_e.neg});
            end
        end
    end

    // present a request, wait for acceptance; returns #1 after the accept edge
    task automatic issue(input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic push,
                         input res_t e);
        int n;
        n = 0;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        if (push) sb_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 64'hDEAD_BEEF_0BAD_F00D;
        bus.in_b     = 64'h1234_5678_9ABC_DEF0;
        bus.in_op    = OP_SUB;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got out_valid 0 expected 1");
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input res_t e);
        issue(op, a, b, 1'b1, e);
        wait_valid();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = OP_ADD;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_add_a",     bus.add_a, 64'd0);
        chk("rst_add_b",     bus.add_b, 64'd0);
        chk("rst_add_c",     {63'd0, bus.add_c}, 64'd0);
        chk("rst_out_s",     bus.out_s, 64'd0);
        chk("rst_flags", {60'd0, bus.out_cout, bus.out_ovf,
                          bus.out_zero, bus.out_neg}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD all-ones + 1: wraps to zero with carry out
        issue(OP_ADD, ONES, 64'd1, 1'b1, mk(64'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        chk("add1_add_a", bus.add_a, ONES);
        chk("add1_add_b", bus.add_b, 64'd1);
        chk("add1_add_c", {63'd0, bus.add_c}, 64'd0);
        chk("add1_exec_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("add1_exec_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("add1_latency_valid", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk); #1;
        chk("add1_consumed", {63'd0, bus.out_valid}, 64'd0);

        // ADC 0+0 chains the carry from the previous result
        issue(OP_ADC, 64'd0, 64'd0, 1'b1, mk(64'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("adc_add_c", {63'd0, bus.add_c}, 64'd1);
        wait_valid();
        @(posedge clk); #1;

        // SUB 5-7 = -2, borrow means carry 0
        issue(OP_SUB, 64'd5, 64'd7, 1'b1,
              mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
        chk("sub_add_b", bus.add_b, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sub_add_c", {63'd0, bus.add_c}, 64'd1);
        wait_valid();
        @(posedge clk); #1;

`ifdef CLA_SAT_EN
        run_op(OP_ADD, SMAX, 64'd1, mk(SMAX, 1'b0, 1'b1, 1'b0, 1'b0));
`else
        run_op(OP_ADD, SMAX, 64'd1, mk(SMIN, 1'b0, 1'b1, 1'b0, 1'b1));
`endif

        // backpressure: result held while out_ready is low
        bus.out_ready = 1'b0;
        issue(OP_ADD, 64'd3, 64'd4, 1'b1, mk(64'd7, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid",    {63'd0, bus.out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, bus.in_ready},  64'd0);
            chk("bp_out_s",    bus.out_s, 64'd7);
            chk("bp_flags", {60'd0, bus.out_cout, bus.out_ovf,
                             bus.out_zero, bus.out_neg}, 64'd0);
        end
        bus.in_op     = OP_SUB;
        bus.in_a      = 64'd10;
        bus.in_b      = 64'd3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_same_edge_ready", {63'd0, bus.in_ready}, 64'd1);
        sb_q.push_back(mk(64'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_reload_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("bp_reload_a", bus.add_a, 64'd10);
        chk("bp_reload_b", bus.add_b, ~64'd3);
        @(posedge clk); #1;
        chk("bp_next_valid", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk); #1;

        // async reset mid-EXEC discards the in-flight op and cflag
        issue(OP_ADD, 64'd1, 64'd1, 1'b0, mk(64'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("arst_add_a",     bus.add_a, 64'd0);
        chk("arst_add_b",     bus.add_b, 64'd0);
        chk("arst_add_c",     {63'd0, bus.add_c}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_no_output", {63'd0, bus.out_valid}, 64'd0);

        issue(OP_ADC, 64'd0, 64'd0, 1'b1, mk(64'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        chk("arst_adc_add_c", {63'd0, bus.add_c}, 64'd0);
        wait_valid();
        @(posedge clk); #1;

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
